decode_stage: RTL and testbench
===============================

# decode_stage

Instruction-decode stage of the 5-stage 16-bit pipeline. It sits between the IF/ID register and the ID/EX register and drives every `D_*` input of the ID/EX register. The block holds the 16×16 register file and decodes the opcode into control signals. It also resolves B/BR branches against the EX-stage flags and detects load-use and flag/branch hazards, producing stall and flush requests. It latches HLT so that the pipeline drains and stops.

## Interface
No parameters.

**Clock and reset**
- `clk` in 1: pipeline clock; all state is updated on its rising edge.
- `rst_n` in 1: asynchronous, active-low reset.

**From IF/ID**
- `F_Instr` in 16: instruction word.
- `F_Nxt_Pc` in 16: PC+2 of the instruction.

**Writeback**
- `W_RegWrite` in 1: register-file write enable.
- `W_Destination` in 4: write index.
- `W_Data` in 16: write data.

**Hazard inputs**
- `X_Destination` in 4, `X_RegWrite` in 1, `X_MemRead` in 1: instruction currently in EX.
- `X_SetsFlags` in 1: EX instruction updates the Z/V/N flags.
- `M_Destination` in 4, `M_RegWrite` in 1: instruction currently in MEM.
- `Flags` in 3: {Z,V,N} flag register output in EX.

**To ID/EX**
- `D_Operand1`, `D_Operand2_Mux`, `D_Operand2_Fw`, `D_Destination`, `D_Opcode` out 4.
- `D_Operand1_Out`, `D_Operand2_Out`, `D_Nxt_Pc` out 16.
- `D_hlt`, `D_ALUSrc`, `D_MemtoReg`, `D_MemRead`, `D_MemWrite`, `D_RegWrite`, `D_Pcs`, `D_load_byte`, `D_sw` out 1.

**To fetch**
- `D_Stall` out 1: hold PC and IF/ID.
- `D_Flush` out 1: load NOP into IF/ID.
- `D_Branch_Taken` out 1: PC takes the branch target.
- `D_Branch_Target` out 16: branch target address.

## Operation

**Field extraction**
- `D_Opcode` = [15:12].
- `D_Operand1` = [7:4]; it is [11:8] for LLB/LHB (0xA/0xB).
- `D_Operand2_Mux` = [3:0].
- `D_Operand2_Fw` = [3:0]; it is [11:8] for SW (0x9).
- `D_Destination` = [11:8].
- `D_Nxt_Pc` = `F_Nxt_Pc`.

**Register file**
- 16×16 array; all entries are 0 after reset.
- R0 always reads 0; writes to R0 are dropped.
- Write on posedge when `W_RegWrite` is high.
- Write-through bypass: if a read index equals `W_Destination` (nonzero) while `W_RegWrite` is high, the read returns `W_Data` in the same cycle.
- `D_Operand1_Out` = reg[`D_Operand1`]; `D_Operand2_Out` = reg[`D_Operand2_Fw`].

**Control decode**
- `RegWrite`: opcodes 0–8, A, B, E.
- `ALUSrc`: opcodes 4, 5, 6, 8, 9, A, B.
- `MemRead` = `MemtoReg`: opcode 8.
- `MemWrite` = `sw`: opcode 9.
- `load_byte`: A, B.
- `Pcs`: E.
- `hlt`: F.

**Branch resolution** (unstalled only)
- Condition ccc = [11:9]:
  - 000: Z=0
  - 001: Z=1
  - 010: Z=0 and N=0
  - 011: N=1
  - 100: Z=1 or (Z=0 and N=0)
  - 101: N=1 or Z=1
  - 110: V=1
  - 111: always
- B (0xC) target = `F_Nxt_Pc` + (sext([8:0]) << 1), 16-bit wrap.
- BR (0xD) target = `D_Operand1_Out`.
- When the condition is true: `D_Branch_Taken` = 1 and `D_Flush` = 1. The branch itself still goes to ID/EX as a no-write instruction.

**Hazards** (`D_Stall` = 1 when any of the following holds)
- Load-use: `X_MemRead`, `X_Destination` ≠ 0, and `X_Destination` matches a register actually read (`D_Operand1` for non-B/HLT/PCS; `D_Operand2_Fw` for opcodes 0–3, 7, 9).
- Flag hazard: opcode C/D with ccc ≠ 111 and `X_SetsFlags`.
- BR register hazard: `D_Operand1` ≠ 0 and equals `X_Destination` with `X_RegWrite`, or `M_Destination` with `M_RegWrite`.

**Bubble**
- While stalled, all nine control outputs = 0, and `D_Branch_Taken` = `D_Flush` = 0.
- Stall has priority over branch.

**Halt latch**
- `halted` is set on posedge when opcode F is decoded unstalled.
- While `halted`: `D_Stall` = 1 and the bubble is forced.
- Cleared only by reset.

## Timing
- Decode, hazard and branch outputs are combinational from `F_*`, `X_*`, `M_*`, `Flags` and the register file: zero-cycle latency into ID/EX.
- The register-file write lands at posedge; the bypass makes the new value visible in the same cycle as the write.
- Load-use stall lasts exactly 1 cycle. A BR register hazard lasts up to 2 cycles (X, then M). A flag hazard lasts 1 cycle.
- HLT: `D_hlt` is asserted for exactly one decode cycle. From the next cycle, `D_Stall` stays at 1 permanently.
- During `rst_n` = 0:
  - all control outputs, `D_Stall`, `D_Flush` and `D_Branch_Taken` are forced to 0;
  - `D_Branch_Target` = 0;
  - the register file is cleared and `halted` = 0.
- Reset is asynchronous, so it also clears state mid-stall or mid-halt.

## Test plan
- Write R3 = 0x1234 (`W_*`) while decoding ADD R1,R3,R2 in the same cycle → `D_Operand1_Out` = 0x1234 via bypass. Writing R0 = 0xFFFF → R0 still reads 0.
- EX holds LW R4 with `X_MemRead` = 1; decode SUB R5,R4,R6 → `D_Stall` = 1 with all controls 0 for 1 cycle. With `X_MemRead` dropped, SUB issues with `D_RegWrite` = 1.
- B ccc=001, imm = −2 (0x1FE), `F_Nxt_Pc` = 0x0010, `Flags` = 100 → `D_Branch_Taken` = 1, `D_Flush` = 1, target = 0x000C. With `Flags` = 000 → not taken.
- B ccc=000 while `X_SetsFlags` = 1 → stall 1 cycle, no `D_Branch_Taken`. Same instruction with ccc=111 → taken immediately.
- BR R7 with `X_Destination` = 7 / `X_RegWrite`, then next cycle `M_Destination` = 7 / `M_RegWrite` → stall 2 cycles. Then target = reg[7].
- Decode HLT → `D_hlt` = 1 for one cycle, then `D_Stall` = 1 indefinitely. Pulse `rst_n` low → `D_Stall` = 0 and R1–R15 read 0.

Source files
------------

// File: rtl/decode_stage.sv
// Instruction-decode stage: register file, control decode, branch resolution,
// hazard detection and the sticky halt latch.
module decode_stage (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] F_Instr,
    input  logic [15:0] F_Nxt_Pc,
    input  logic        W_RegWrite,
    input  logic [3:0]  W_Destination,
    input  logic [15:0] W_Data,
    input  logic [3:0]  X_Destination,
    input  logic        X_RegWrite,
    input  logic        X_MemRead,
    input  logic        X_SetsFlags,
    input  logic [3:0]  M_Destination,
    input  logic        M_RegWrite,
    input  logic [2:0]  Flags,
    output logic [3:0]  D_Operand1,
    output logic [3:0]  D_Operand2_Mux,
    output logic [3:0]  D_Operand2_Fw,
    output logic [3:0]  D_Destination,
    output logic [3:0]  D_Opcode,
    output logic [15:0] D_Operand1_Out,
    output logic [15:0] D_Operand2_Out,
    output logic [15:0] D_Nxt_Pc,
    output logic        D_hlt,
    output logic        D_ALUSrc,
    output logic        D_MemtoReg,
    output logic        D_MemRead,
    output logic        D_MemWrite,
    output logic        D_RegWrite,
    output logic        D_Pcs,
    output logic        D_load_byte,
    output logic        D_sw,
    output logic        D_Stall,
    output logic        D_Flush,
    output logic        D_Branch_Taken,
    output logic [15:0] D_Branch_Target
);

    typedef enum logic {RUN, HALTED} run_state_t;

    run_state_t  state_q, state_d;
    logic [15:0] regs [16];
    logic [3:0]  opcode;
    logic [2:0]  ccc;
    logic        cond, is_branch;
    logic        reads_op1, reads_op2;
    logic        load_use, flag_haz, br_haz, hazard, stall, bubble;
    logic [15:0] b_target;

    always_comb begin
        opcode         = F_Instr[15:12];
        ccc            = F_Instr[11:9];
        D_Opcode       = opcode;
        D_Destination  = F_Instr[11:8];
        D_Operand2_Mux = F_Instr[3:0];
        D_Operand1     = (opcode == 4'hA || opcode == 4'hB) ? F_Instr[11:8] : F_Instr[7:4];
        D_Operand2_Fw  = (opcode == 4'h9) ? F_Instr[11:8] : F_Instr[3:0];
        D_Nxt_Pc       = F_Nxt_Pc;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < 16; i++) regs[i] <= '0;
        end else if (W_RegWrite && W_Destination != 4'h0) begin
            regs[W_Destination] <= W_Data;
        end
    end

    // Write-through bypass: a same-cycle writeback is visible to decode.
    always_comb begin
        if (D_Operand1 == 4'h0)
            D_Operand1_Out = '0;
        else if (W_RegWrite && W_Destination == D_Operand1)
            D_Operand1_Out = W_Data;
        else
            D_Operand1_Out = regs[D_Operand1];

        if (D_Operand2_Fw == 4'h0)
            D_Operand2_Out = '0;
        else if (W_RegWrite && W_Destination == D_Operand2_Fw)
            D_Operand2_Out = W_Data;
        else
            D_Operand2_Out = regs[D_Operand2_Fw];
    end

    always_comb begin
        reads_op1 = !(opcode inside {4'hC, 4'hE, 4'hF});
        reads_op2 = opcode inside {4'h0, 4'h1, 4'h2, 4'h3, 4'h7, 4'h9};
        is_branch = opcode inside {4'hC, 4'hD};
        load_use  = X_MemRead && X_Destination != 4'h0 &&
                    ((reads_op1 && X_Destination == D_Operand1) ||
                     (reads_op2 && X_Destination == D_Operand2_Fw));
        flag_haz  = is_branch && ccc != 3'b111 && X_SetsFlags;
        br_haz    = opcode == 4'hD && D_Operand1 != 4'h0 &&
                    ((X_RegWrite && X_Destination == D_Operand1) ||
                     (M_RegWrite && M_Destination == D_Operand1));
        hazard    = load_use || flag_haz || br_haz;
        stall     = (state_q == HALTED) || hazard;
        bubble    = stall || !rst_n;
    end

    // Flags are {Z,V,N}.
    always_comb begin
        unique case (ccc)
            3'b000:  cond = !Flags[2];
            3'b001:  cond = Flags[2];
            3'b010:  cond = !Flags[2] && !Flags[0];
            3'b011:  cond = Flags[0];
            3'b100:  cond = Flags[2] || !Flags[0];
            3'b101:  cond = Flags[0] || Flags[2];
            3'b110:  cond = Flags[1];
            default: cond = 1'b1;
        endcase
        b_target = F_Nxt_Pc + {{6{F_Instr[8]}}, F_Instr[8:0], 1'b0};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= RUN;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (state_q == RUN && opcode == 4'hF && !hazard) state_d = HALTED;
    end

    always_comb begin
        D_RegWrite      = !bubble && (opcode inside {[4'h0:4'h8], 4'hA, 4'hB, 4'hE});
        D_ALUSrc        = !bubble && (opcode inside {4'h4, 4'h5, 4'h6, [4'h8:4'hB]});
        D_MemRead       = !bubble && opcode == 4'h8;
        D_MemtoReg      = D_MemRead;
        D_MemWrite      = !bubble && opcode == 4'h9;
        D_sw            = D_MemWrite;
        D_load_byte     = !bubble && (opcode inside {4'hA, 4'hB});
        D_Pcs           = !bubble && opcode == 4'hE;
        D_hlt           = !bubble && opcode == 4'hF;
        D_Stall         = rst_n && stall;
        D_Branch_Taken  = !bubble && is_branch && cond;
        D_Flush         = D_Branch_Taken;
        if (!rst_n)
            D_Branch_Target = '0;
        else if (opcode == 4'hD)
            D_Branch_Target = D_Operand1_Out;
        else
            D_Branch_Target = b_target;
    end

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: directed scenarios plus randomized
// decode compared against a behavioural model of the stage.
module tb_decode_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] instr, nxt_pc, w_data;
    logic        w_rw, x_rw, x_mr, x_sf, m_rw;
    logic [3:0]  w_d, x_d, m_d;
    logic [2:0]  flags;

    logic [3:0]  o_op1, o_op2m, o_op2f, o_dst, o_opc;
    logic [15:0] o_v1, o_v2, o_npc, o_tgt;
    logic        o_hlt, o_alusrc, o_m2r, o_mrd, o_mwr, o_rw, o_pcs, o_lb, o_sw;
    logic        o_stall, o_flush, o_taken;

    int total = 0;
    int bad   = 0;

    logic [15:0] mreg [16];
    bit          mhalted;

    // Opcode membership tables: bit i set means opcode i asserts the signal.
    localparam logic [15:0] RW_SET    = 16'h4DFF;
    localparam logic [15:0] ALU_SET   = 16'h0F70;
    localparam logic [15:0] LB_SET    = 16'h0C00;
    localparam logic [15:0] READ2_SET = 16'h028F;

    always #5 clk = ~clk;

    decode_stage dut (
        .clk(clk), .rst_n(rst_n), .F_Instr(instr), .F_Nxt_Pc(nxt_pc),
        .W_RegWrite(w_rw), .W_Destination(w_d), .W_Data(w_data),
        .X_Destination(x_d), .X_RegWrite(x_rw), .X_MemRead(x_mr), .X_SetsFlags(x_sf),
        .M_Destination(m_d), .M_RegWrite(m_rw), .Flags(flags),
        .D_Operand1(o_op1), .D_Operand2_Mux(o_op2m), .D_Operand2_Fw(o_op2f),
        .D_Destination(o_dst), .D_Opcode(o_opc),
        .D_Operand1_Out(o_v1), .D_Operand2_Out(o_v2), .D_Nxt_Pc(o_npc),
        .D_hlt(o_hlt), .D_ALUSrc(o_alusrc), .D_MemtoReg(o_m2r), .D_MemRead(o_mrd),
        .D_MemWrite(o_mwr), .D_RegWrite(o_rw), .D_Pcs(o_pcs), .D_load_byte(o_lb),
        .D_sw(o_sw), .D_Stall(o_stall), .D_Flush(o_flush),
        .D_Branch_Taken(o_taken), .D_Branch_Target(o_tgt)
    );

    logic [95:0] act;
    assign act = {o_op1, o_op2m, o_op2f, o_dst, o_opc, o_v1, o_v2, o_npc,
                  o_hlt, o_alusrc, o_m2r, o_mrd, o_mwr, o_rw, o_pcs, o_lb, o_sw,
                  o_stall, o_flush, o_taken, o_tgt};

    function automatic logic [15:0] m_read(input logic [3:0] idx);
        if (idx == 4'h0) return 16'h0;
        if (w_rw && w_d == idx) return w_data;
        return mreg[idx];
    endfunction

    function automatic int src1();
        int op = int'(instr[15:12]);
        return (op == 10 || op == 11) ? int'(instr[11:8]) : int'(instr[7:4]);
    endfunction

    function automatic int src2();
        return (instr[15:12] == 4'h9) ? int'(instr[11:8]) : int'(instr[3:0]);
    endfunction

    function automatic bit m_cond();
        bit z = flags[2], v = flags[1], n = flags[0];
        case (instr[11:9])
            3'd0: return !z;
            3'd1: return z;
            3'd2: return !z && !n;
            3'd3: return n;
            3'd4: return z || !n;
            3'd5: return n || z;
            3'd6: return v;
            default: return 1'b1;
        endcase
    endfunction

    function automatic bit m_stall();
        int  op = int'(instr[15:12]);
        int  s1 = src1(), s2 = src2(), xd = int'(x_d), md = int'(m_d);
        bit  r1 = !(op == 12 || op == 14 || op == 15);
        bit  r2 = READ2_SET[op];
        bit  lu = x_mr && xd != 0 && ((r1 && xd == s1) || (r2 && xd == s2));
        bit  fh = (op == 12 || op == 13) && instr[11:9] != 3'd7 && x_sf;
        bit  bh = op == 13 && s1 != 0 && ((x_rw && xd == s1) || (m_rw && md == s1));
        return mhalted || lu || fh || bh;
    endfunction

    function automatic logic [95:0] model_out();
        int          op = int'(instr[15:12]);
        bit          live = rst_n && !m_stall();
        logic [8:0]  ctrl;
        logic [15:0] tgt;
        logic [15:0] v1 = m_read(4'(src1()));
        int          off = int'(instr[8:0]);
        bit          tk;
        if (off >= 256) off -= 512;
        ctrl = {op == 15, ALU_SET[op], op == 8, op == 8, op == 9, RW_SET[op],
                op == 14, LB_SET[op], op == 9};
        if (!live) ctrl = '0;
        tgt = (op == 13) ? v1 : 16'(int'(nxt_pc) + 2 * off);
        if (!rst_n) tgt = '0;
        tk = live && (op == 12 || op == 13) && m_cond();
        return {4'(src1()), instr[3:0], 4'(src2()), instr[11:8], instr[15:12],
                v1, m_read(4'(src2())), nxt_pc, ctrl,
                rst_n && m_stall(), tk, tk, tgt};
    endfunction

    task automatic tick();
        bit st = m_stall();
        @(posedge clk);
        if (!rst_n) begin
            foreach (mreg[i]) mreg[i] = '0;
            mhalted = 0;
        end else begin
            if (w_rw && w_d != 4'h0) mreg[w_d] = w_data;
            if (instr[15:12] == 4'hF && !st) mhalted = 1;
        end
        #1;
    endtask

    task automatic quiet();
        w_rw = 0; w_d = 0; w_data = 0; x_d = 0; x_rw = 0; x_mr = 0; x_sf = 0;
        m_d = 0; m_rw = 0; flags = 0; nxt_pc = 16'h0100; instr = 16'h0000;
    endtask

    task automatic test_reset();
        quiet();
        rst_n  = 0;
        instr  = 16'hCFFE;
        flags  = 3'b111;
        foreach (mreg[i]) mreg[i] = '0;
        mhalted = 0;
        #2;
        total++;
        if ({o_stall, o_flush, o_taken, o_rw, o_hlt} !== 5'b0 || o_tgt !== 16'h0) begin
            bad++;
            $display("FAIL reset_outputs: got stall/flush/taken=%b%b%b tgt=%h want 000 tgt=0000",
                     o_stall, o_flush, o_taken, o_tgt);
        end
        tick();
        rst_n = 1;
        instr = 16'h0012;
        #1;
        total++;
        if (o_v1 !== 16'h0 || o_stall !== 1'b0) begin
            bad++;
            $display("FAIL reset_regfile: got R1=%h stall=%b want 0000 0", o_v1, o_stall);
        end
        tick();
    endtask

    task automatic test_bypass();
        quiet();
        instr = 16'h0132;
        w_rw = 1; w_d = 4'd3; w_data = 16'h1234;
        #1;
        total++;
        if (o_v1 !== 16'h1234) begin
            bad++;
            $display("FAIL bypass_r3: got %h want 1234", o_v1);
        end
        tick();
        w_rw = 0;
        #1;
        total++;
        if (o_v1 !== 16'h1234) begin
            bad++;
            $display("FAIL stored_r3: got %h want 1234", o_v1);
        end
        tick();
        instr = 16'h0102;
        w_rw = 1; w_d = 4'd0; w_data = 16'hFFFF;
        #1;
        total++;
        if (o_v1 !== 16'h0) begin
            bad++;
            $display("FAIL r0_bypass: got %h want 0000", o_v1);
        end
        tick();
        w_rw = 0;
        #1;
        total++;
        if (o_v1 !== 16'h0) begin
            bad++;
            $display("FAIL r0_write: got %h want 0000", o_v1);
        end
        tick();
    endtask

    task automatic test_load_use();
        quiet();
        instr = 16'h1546;
        x_d = 4'd4; x_mr = 1; x_rw = 1;
        #1;
        total++;
        if (o_stall !== 1'b1 || {o_rw, o_alusrc, o_mrd, o_mwr, o_hlt, o_pcs, o_lb, o_sw, o_m2r} !== 9'b0) begin
            bad++;
            $display("FAIL load_use_stall: got stall=%b rw=%b want 1 0", o_stall, o_rw);
        end
        tick();
        x_mr = 0; x_rw = 0;
        #1;
        total++;
        if (o_stall !== 1'b0 || o_rw !== 1'b1) begin
            bad++;
            $display("FAIL load_use_issue: got stall=%b rw=%b want 0 1", o_stall, o_rw);
        end
        tick();
    endtask

    task automatic test_branch();
        quiet();
        instr = 16'hC3FE; nxt_pc = 16'h0010; flags = 3'b100;
        #1;
        total++;
        if (o_taken !== 1'b1 || o_flush !== 1'b1 || o_tgt !== 16'h000C || o_rw !== 1'b0) begin
            bad++;
            $display("FAIL b_taken: got taken=%b flush=%b tgt=%h want 1 1 000c", o_taken, o_flush, o_tgt);
        end
        tick();
        flags = 3'b000;
        #1;
        total++;
        if (o_taken !== 1'b0 || o_flush !== 1'b0) begin
            bad++;
            $display("FAIL b_not_taken: got taken=%b flush=%b want 0 0", o_taken, o_flush);
        end
        tick();
    endtask

    task automatic test_flag_hazard();
        quiet();
        instr = 16'hC1FE; x_sf = 1;
        #1;
        total++;
        if (o_stall !== 1'b1 || o_taken !== 1'b0) begin
            bad++;
            $display("FAIL flag_haz: got stall=%b taken=%b want 1 0", o_stall, o_taken);
        end
        tick();
        instr = 16'hCFFE; nxt_pc = 16'h0010;
        #1;
        total++;
        if (o_stall !== 1'b0 || o_taken !== 1'b1 || o_tgt !== 16'h000C) begin
            bad++;
            $display("FAIL flag_always: got stall=%b taken=%b tgt=%h want 0 1 000c", o_stall, o_taken, o_tgt);
        end
        tick();
    endtask

    task automatic test_br_hazard();
        quiet();
        w_rw = 1; w_d = 4'd7; w_data = 16'hBEEF;
        tick();
        quiet();
        instr = 16'hDE70; x_d = 4'd7; x_rw = 1;
        #1;
        total++;
        if (o_stall !== 1'b1 || o_taken !== 1'b0) begin
            bad++;
            $display("FAIL br_haz_x: got stall=%b taken=%b want 1 0", o_stall, o_taken);
        end
        tick();
        x_rw = 0; x_d = 0; m_d = 4'd7; m_rw = 1;
        #1;
        total++;
        if (o_stall !== 1'b1 || o_taken !== 1'b0) begin
            bad++;
            $display("FAIL br_haz_m: got stall=%b taken=%b want 1 0", o_stall, o_taken);
        end
        tick();
        m_rw = 0; m_d = 0;
        #1;
        total++;
        if (o_stall !== 1'b0 || o_taken !== 1'b1 || o_tgt !== 16'hBEEF) begin
            bad++;
            $display("FAIL br_target: got stall=%b taken=%b tgt=%h want 0 1 beef", o_stall, o_taken, o_tgt);
        end
        tick();
    endtask

    task automatic test_random_decode();
        logic [95:0] exp;
        for (int n = 0; n < 300; n++) begin
            instr  = 16'($urandom);
            instr[15:12] = 4'($urandom_range(0, 14));
            nxt_pc = 16'($urandom);
            flags  = 3'($urandom);
            w_rw   = 1'($urandom);
            w_d    = 4'($urandom);
            w_data = 16'($urandom);
            x_d    = 4'($urandom);
            x_rw   = ($urandom_range(0, 3) == 0);
            x_mr   = ($urandom_range(0, 3) == 0);
            x_sf   = ($urandom_range(0, 3) == 0);
            m_d    = 4'($urandom);
            m_rw   = ($urandom_range(0, 3) == 0);
            #1;
            exp = model_out();
            total++;
            if (act !== exp) begin
                bad++;
                $display("FAIL random_decode[%0d] instr=%h: got %h want %h", n, instr, act, exp);
            end
            tick();
        end
    endtask

    task automatic test_halt();
        quiet();
        instr = 16'hF000;
        #1;
        total++;
        if (o_hlt !== 1'b1 || o_stall !== 1'b0) begin
            bad++;
            $display("FAIL hlt_decode: got hlt=%b stall=%b want 1 0", o_hlt, o_stall);
        end
        tick();
        for (int n = 0; n < 6; n++) begin
            instr = 16'($urandom);
            #1;
            total++;
            if (o_stall !== 1'b1 || o_hlt !== 1'b0 || o_rw !== 1'b0 || o_taken !== 1'b0) begin
                bad++;
                $display("FAIL halted[%0d]: got stall=%b hlt=%b rw=%b taken=%b want 1 0 0 0",
                         n, o_stall, o_hlt, o_rw, o_taken);
            end
            tick();
        end
        #2;
        rst_n = 0;
        #1;
        total++;
        if (o_stall !== 1'b0) begin
            bad++;
            $display("FAIL halt_reset: got stall=%b want 0", o_stall);
        end
        tick();
        rst_n = 1;
        instr = 16'h0000;
        for (int r = 1; r < 16; r++) begin
            instr = 16'(r << 4);
            #1;
            total++;
            if (o_v1 !== 16'h0 || o_stall !== 1'b0) begin
                bad++;
                $display("FAIL cleared_r%0d: got %h stall=%b want 0000 0", r, o_v1, o_stall);
            end
            tick();
        end
    endtask

    initial begin
        quiet();
        rst_n = 0;
        #1;
        test_reset();
        test_bypass();
        test_load_use();
        test_branch();
        test_flag_hazard();
        test_br_hazard();
        test_random_decode();
        test_halt();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
